prga_drop: RTL and testbench
============================

Name: prga_drop

Overview:
- Parametrised successor to the task3 ARC4 PRGA decryptor, reusing the same memory-port style.
- Reads ciphertext from CT memory and the already-scheduled S array, then writes plaintext to PT memory.
- Adds a compile-time keystream drop (RC4-drop[N]), an optional printable-ASCII plaintext check with early abort, and a `valid` result flag.
- Sits between KSA and the task4/5 crack controllers: a failing key is rejected early, without decrypting the whole message.

Parameters:
- DROP_N, 0: number of leading keystream bytes generated and discarded before decryption starts (0..1024).
- CHECK_ASCII, 1: 1 = abort on the first plaintext byte outside [ASCII_LO, ASCII_HI].
- ASCII_LO, 8'h20: lowest accepted plaintext byte.
- ASCII_HI, 8'h7E: highest accepted plaintext byte.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only when rdy=1.
- rdy  out  1  1 = idle and able to accept en.
- valid  out  1  result of the last run: 1 = every written plaintext byte passed the check (always 1 if CHECK_ASCII=0).
- s_addr  out  8  S memory address.
- s_rddata  in  8  S read data, valid the cycle after s_addr is presented.
- s_wrdata  out  8  S write data.
- s_wren  out  1  S write enable.
- ct_addr  out  8  CT address; ct[0] holds the message length.
- ct_rddata  in  8  CT read data, 1-cycle latency.
- pt_addr  out  8  PT address.
- pt_wrdata  out  8  PT write data.
- pt_wren  out  1  PT write enable.

Behaviour:
- Reset values: state IDLE, rdy=1, valid=0, s_wren=0, pt_wren=0, all addresses 0; i, j, cnt, m and len cleared.
- All memories are synchronous-read, 1-cycle latency. Each state below lists what it drives and what it captures.
- IDLE:
  - Drives rdy=1, ct_addr=0.
  - en=1 → LEN, clear valid to 1. en while rdy=0 is ignored.
- LEN:
  - Captures len=ct_rddata; writes pt[0]=len.
  - Clears i=j=0, cnt=0, m=1.
  - If DROP_N+len==0 → DONE, else → RI.
- RI: s_addr=i+1; i<=i+1.
- RJ: si<=s_rddata; s_addr=j+s_rddata; j<=j+s_rddata.
- WJ: sj<=s_rddata; write s[j]=si.
- WI: write s[i]=sj.
- PAD: s_addr=si+sj (mod 256, no write); ct_addr=m.
- XOR: pad=s_rddata.
  - If cnt<DROP_N: no PT write.
  - Else: write pt[m]=pad^ct_rddata; m<=m+1.
  - cnt<=cnt+1.
  - If CHECK_ASCII and the written byte is outside [ASCII_LO, ASCII_HI]: valid<=0 → DONE. The failing byte is still written.
  - Else if cnt+1==DROP_N+len → DONE, else → RI.
- DONE: one cycle, rdy=0 → IDLE.
- Latency: 6 cycles per keystream byte.
  - Full run: en sampled → rdy high again after 3+6*(DROP_N+len) cycles.
- Arithmetic and widths:
  - i, j and S indexing are 8-bit wrap-around.
  - cnt width is clog2(DROP_N+256).
  - m never exceeds 255.
- s_wren and pt_wren are never asserted in the same cycle as a read of the same memory.
- Reset mid-operation takes effect immediately:
  - All wren drop; state returns to IDLE, rdy=1, valid=0.
  - Partial PT/S contents are left as is.
- valid holds its value until the next accepted en.

Decomposition:
- Shared package arc4_pkg: state enum (IDLE, LEN, RI, RJ, WJ, WI, PAD, XOR, DONE), LEN_ADDR=8'd0, default ASCII_LO/ASCII_HI.
- Single module; no sub-module warranted (the range check is one comparison).

Test Plan:
- Bench memories: S = identity (s[x]=x), writes modelled. This gives keystream 2, 5, …
- Basic, DROP_N=0: ct={02,43,47} → pt={02,41,42}, valid=1, rdy returns 15 cycles after en.
- Drop, DROP_N=1: ct={01,44} → first keystream byte 02 discarded, pt={01,41}, no PT write during the first keystream byte, valid=1.
- Abort, CHECK_ASCII=1: ct={02,02,47} → pt[1]=00 written, valid=0, pt[2] never written, rdy returns 9 cycles after en.
- Zero length: ct={00} → pt[0]=00, no s_wren/s_addr activity, valid=1, rdy back after 3 cycles.
- Robustness:
  - en pulsed during RJ is ignored.
  - rst asserted during WJ → same-cycle s_wren=0, rdy=1, valid=0.
  - A fresh en then reruns the basic case correctly after S is reloaded.

Source files
------------

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 PRGA state encoding, addresses and printable-range helper
package arc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    RI,
    RJ,
    WJ,
    WI,
    PAD,
    XOR,
    DONE
  } state_t;

  localparam logic [7:0] LEN_ADDR     = 8'd0;
  localparam logic [7:0] ASCII_LO_DEF = 8'h20;
  localparam logic [7:0] ASCII_HI_DEF = 8'h7E;

  function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/prga_drop.sv
// rtl/prga_drop.sv - ARC4 PRGA decryptor with RC4-drop[N] and printable-plaintext early abort
module prga_drop
  import arc4_pkg::*;
#(
  parameter int         DROP_N      = 0,
  parameter bit         CHECK_ASCII = 1'b1,
  parameter logic [7:0] ASCII_LO    = ASCII_LO_DEF,
  parameter logic [7:0] ASCII_HI    = ASCII_HI_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       valid,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  localparam int             CNT_W  = $clog2(DROP_N + 256);
  localparam logic [CNT_W:0] DROP_W = (CNT_W + 1)'(DROP_N);
  localparam logic [CNT_W:0] ONE_W  = (CNT_W + 1)'(1);

  state_t             state_q;
  logic [7:0]         i_q, j_q, si_q, sj_q, m_q, len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               drop_q, rdy_q, valid_q;

  logic [7:0]         j_sum, pt_byte;
  logic [CNT_W:0]     cnt_inc, total_len, total_ct;
  logic               byte_bad;

  assign j_sum     = j_q + s_rddata;
  assign pt_byte   = s_rddata ^ ct_rddata;
  assign cnt_inc   = {1'b0, cnt_q} + ONE_W;
  assign total_len = DROP_W + (CNT_W + 1)'(len_q);
  assign total_ct  = DROP_W + (CNT_W + 1)'(ct_rddata);
  assign byte_bad  = CHECK_ASCII && !drop_q && !in_range(pt_byte, ASCII_LO, ASCII_HI);

  assign rdy   = rdy_q;
  assign valid = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      m_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            valid_q <= 1'b1;
            rdy_q   <= 1'b0;
            state_q <= LEN;
          end
        end
        LEN: begin
          len_q   <= ct_rddata;
          i_q     <= '0;
          j_q     <= '0;
          cnt_q   <= '0;
          m_q     <= 8'd1;
          drop_q  <= (DROP_N != 0);
          state_q <= (total_ct == '0) ? DONE : RI;
        end
        RI: begin
          i_q     <= i_q + 8'd1;
          state_q <= RJ;
        end
        RJ: begin
          si_q    <= s_rddata;
          j_q     <= j_sum;
          state_q <= WJ;
        end
        WJ: begin
          sj_q    <= s_rddata;
          state_q <= WI;
        end
        WI:  state_q <= PAD;
        PAD: state_q <= XOR;
        XOR: begin
          cnt_q <= cnt_inc[CNT_W-1:0];
          if (!drop_q) m_q <= m_q + 8'd1;
          if (cnt_inc == DROP_W) drop_q <= 1'b0;
          if (byte_bad) begin
            valid_q <= 1'b0;
            state_q <= DONE;
          end else if (cnt_inc == total_len) begin
            state_q <= DONE;
          end else begin
            state_q <= RI;
          end
        end
        DONE: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory ports are decoded from state: RJ, LEN and XOR consume read data in the same
  // cycle it arrives, so their address/data cannot be registered a cycle ahead.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = LEN_ADDR;
    pt_addr   = LEN_ADDR;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state_q)
      LEN: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      RI: s_addr = i_q + 8'd1;
      RJ: s_addr = j_sum;
      WJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      WI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
      end
      PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = m_q;
      end
      XOR: begin
        ct_addr   = m_q;
        pt_addr   = m_q;
        pt_wrdata = pt_byte;
        pt_wren   = !drop_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_drop.sv
// tb/tb_prga_drop.sv - scoreboard bench for prga_drop, one instance each with DROP_N=0 and DROP_N=1
module tb_prga_drop;
  import arc4_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en        [2];
  logic       rdy       [2];
  logic       valid     [2];
  logic       s_wren    [2];
  logic       pt_wren   [2];
  logic [7:0] s_addr    [2];
  logic [7:0] s_rddata  [2];
  logic [7:0] s_wrdata  [2];
  logic [7:0] ct_addr   [2];
  logic [7:0] ct_rddata [2];
  logic [7:0] pt_addr   [2];
  logic [7:0] pt_wrdata [2];

  logic [7:0] smem  [2][256];
  logic [7:0] ctmem [2][256];
  logic [7:0] sinit [256];
  logic [7:0] ms    [256];
  int         mi, mj;
  wr_t        expq  [2][$];
  bit         s_act [2];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  prga_drop #(.DROP_N(0)) u_d0 (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .valid(valid[0]),
    .s_addr(s_addr[0]), .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
  );

  prga_drop #(.DROP_N(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .valid(valid[1]),
    .s_addr(s_addr[1]), .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
  );

  // Synchronous-read memories; the read samples the old contents before any write.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      s_rddata[k]  <= smem[k][s_addr[k]];
      ct_rddata[k] <= ctmem[k][ct_addr[k]];
      if (s_wren[k]) smem[k][s_addr[k]] = s_wrdata[k];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (s_wren[k] || s_addr[k] != 8'd0) s_act[k] = 1'b1;
      if (!rst && pt_wren[k]) begin
        checks++;
        if (expq[k].size() == 0) begin
          errors++;
          $display("FAIL pt_write dut%0d unexpected addr %h data %h", k, pt_addr[k], pt_wrdata[k]);
        end else begin
          wr_t w;
          w = expq[k].pop_front();
          if (w !== {pt_addr[k], pt_wrdata[k]}) begin
            errors++;
            $display("FAIL pt_write dut%0d got addr %h data %h want addr %h data %h",
                     k, pt_addr[k], pt_wrdata[k], w.a, w.d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) sinit[x] = 8'(x);
  endtask

  task automatic load_random();
    int y;
    logic [7:0] t;
    load_identity();
    for (int x = 255; x > 0; x--) begin
      y = $urandom_range(0, x);
      t = sinit[x];
      sinit[x] = sinit[y];
      sinit[y] = t;
    end
  endtask

  task automatic set_ct(input int k, input logic [63:0] v, input int nb);
    for (int x = 0; x < 256; x++) ctmem[k][x] = (x < nb) ? v[8*x +: 8] : 8'($urandom);
  endtask

  // Textbook RC4 PRGA step on the reference copy of S.
  task automatic next_ks(output logic [7:0] ks);
    logic [7:0] t;
    mi = (mi + 1) % 256;
    mj = (mj + int'(ms[mi])) % 256;
    t = ms[mi];
    ms[mi] = ms[mj];
    ms[mj] = t;
    ks = ms[(int'(ms[mi]) + int'(ms[mj])) % 256];
  endtask

  // mode 0: plain run, 1: en pulsed while in RJ, 2: reset asserted while in WJ
  task automatic run_case(input string name, input int k, input int mode);
    int         len, n, cyc, exp_cyc, mism;
    bit         vexp, stayed;
    logic [7:0] ks, b;
    for (int x = 0; x < 256; x++) begin
      smem[k][x] = sinit[x];
      ms[x] = sinit[x];
    end
    mi = 0;
    mj = 0;
    len = int'(ctmem[k][0]);
    n = 0;
    vexp = 1'b1;
    expq[k].push_back({8'h00, ctmem[k][0]});
    for (int c = 0; c < k + len; c++) begin
      next_ks(ks);
      n++;
      if (c >= k) begin
        b = ks ^ ctmem[k][c-k+1];
        expq[k].push_back({8'(c - k + 1), b});
        if (b < 8'h20 || b > 8'h7E) begin
          vexp = 1'b0;
          break;
        end
      end
    end
    exp_cyc = 3 + 6 * n;
    s_act[k] = 1'b0;

    @(negedge clk);
    en[k] = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1;
    en[k] = 1'b0;
    while (rdy[k] !== 1'b1 && cyc < 2000) begin
      if (mode == 1) en[k] = (cyc == 3);
      if (mode == 2 && cyc == 4) begin
        chk({name, " wj_wren"}, 64'(s_wren[k]), 64'd1);
        rst = 1'b1;
        #1;
        chk({name, " rst_outs"}, {s_wren[k], pt_wren[k], rdy[k], valid[k]}, 64'b0010);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq[k].delete();
        return;
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    en[k] = 1'b0;
    chk({name, " cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({name, " valid"}, 64'(valid[k]), 64'(vexp));
    stayed = 1'b1;
    for (int x = 0; x < 3; x++) begin
      @(posedge clk);
      #1;
      if (rdy[k] !== 1'b1 || valid[k] !== vexp) stayed = 1'b0;
    end
    chk({name, " idle_hold"}, 64'(stayed), 64'd1);
    chk({name, " pt_pending"}, 64'(expq[k].size()), 64'd0);
    mism = 0;
    for (int x = 0; x < 256; x++) if (smem[k][x] !== ms[x]) mism++;
    chk({name, " s_final"}, 64'(mism), 64'd0);
    if (k + len == 0) chk({name, " s_quiet"}, 64'(s_act[k]), 64'd0);
  endtask

  task automatic random_case();
    int         k, len;
    logic [7:0] ks, p;
    k = $urandom_range(0, 1);
    len = $urandom_range(1, 24);
    if ($urandom_range(0, 1) == 0) load_identity();
    else load_random();
    for (int x = 0; x < 256; x++) begin
      ms[x] = sinit[x];
      ctmem[k][x] = 8'($urandom);
    end
    mi = 0;
    mj = 0;
    for (int c = 0; c < k; c++) next_ks(ks);
    ctmem[k][0] = 8'(len);
    for (int x = 1; x <= len; x++) begin
      next_ks(ks);
      if ($urandom_range(0, 11) != 0) p = 8'($urandom_range(32, 126));
      else if ($urandom_range(0, 1) != 0) p = 8'($urandom_range(0, 31));
      else p = 8'($urandom_range(127, 255));
      ctmem[k][x] = p ^ ks;
    end
    run_case("random", k, 0);
  endtask

  initial begin
    rst = 1'b1;
    en[0] = 1'b0;
    en[1] = 1'b0;
    load_identity();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk("reset", {rdy[k], valid[k], s_wren[k], pt_wren[k], s_addr[k], ct_addr[k], pt_addr[k]},
          {36'd0, 1'b1, 27'd0});
    @(negedge clk);
    rst = 1'b0;

    load_identity(); set_ct(0, 64'h47_43_02, 3);       run_case("basic", 0, 0);
    load_identity(); set_ct(1, 64'h44_01, 2);          run_case("drop", 1, 0);
    load_identity(); set_ct(0, 64'h47_02_02, 3);       run_case("abort", 0, 0);
    load_identity(); set_ct(0, 64'h00, 1);             run_case("zero", 0, 0);
    load_identity(); set_ct(0, 64'h78_7B_22_03, 4);    run_case("ascii_hi", 0, 0);
    load_identity(); set_ct(0, 64'h1D_01, 2);          run_case("ascii_lo", 0, 0);
    load_identity(); set_ct(0, 64'h47_43_02, 3);       run_case("en_in_rj", 0, 1);
    load_identity(); set_ct(0, 64'h47_43_02, 3);       run_case("rst_in_wj", 0, 2);
    load_identity(); set_ct(0, 64'h47_43_02, 3);       run_case("rerun", 0, 0);

    for (int r = 0; r < 40; r++) random_case();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
